// File: rtl/scope_pkg.sv
// Shared definitions for the capture path: default bus widths and the
// sequencer state encoding used by the sample-RAM scheduler.
package scope_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFILL  = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POST     = 3'd3,
        ST_CLEAR    = 3'd4,
        ST_RD_ISSUE = 3'd5,
        ST_RD_WAIT  = 3'd6,
        ST_RD_HOLD  = 3'd7
    } state_e;

    // States in which incoming samples are written into the ring.
    function automatic logic is_capture_state(input state_e s);
        return (s == ST_PREFILL) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

    // States in which the RAM address comes from the readout pointer.
    function automatic logic is_read_state(input state_e s);
        return (s == ST_RD_ISSUE) || (s == ST_RD_WAIT) || (s == ST_RD_HOLD);
    endfunction

endpackage

// File: rtl/capture_addr_ctr.sv
// Loadable, enable-driven RAM pointer. Wraps naturally modulo 2**ADDR_W.
module capture_addr_ctr #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] ptr_o
);

    logic [ADDR_W-1:0] ptr_q;

    // Pointer register: a load takes precedence over an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (load_i) begin
            ptr_q <= load_val_i;
        end else if (en_i) begin
            ptr_q <= ptr_q + ADDR_W'(1'b1);
        end else begin
            ptr_q <= ptr_q;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/capture_buf_sched.sv
// Sample-RAM sequencer for the capture path: pre-trigger ring fill, trigger
// wait, post-trigger fill, then ordered readout over a valid/ready port.
module capture_buf_sched
    import scope_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PRE_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic              sample_en_i,
    input  logic              trig_i,
    output logic              rst_trig_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wren_o,
    output logic              mem_rden_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] PRE_A       = ADDR_W'(PRE_DEPTH);
    localparam logic [CNT_W-1:0]  ONE_C       = CNT_W'(1);
    localparam logic [CNT_W-1:0]  PRE_LAST_C  = CNT_W'(PRE_DEPTH - 1);
    localparam logic [CNT_W-1:0]  POST_LAST_C = CNT_W'(DEPTH - PRE_DEPTH - 1);
    localparam logic [CNT_W-1:0]  RD_LAST_C   = CNT_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_s, rd_ptr_s, wr_ptr_next_s;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              wren_s, wr_load_s, rd_load_s, rd_en_s;
    logic              rst_trig_d, done_d;
    logic              rst_trig_q, done_q, mem_rden_q, out_valid_q, busy_q;

    // Writes happen on every sample strobe while the ring is being filled.
    assign wren_s = sample_en_i & is_capture_state(state_q);

    // Pointer value after this cycle's possible write; used so that a write in
    // the trigger cycle is counted as the newest pre-trigger sample.
    assign wr_ptr_next_s = wren_s ? (wr_ptr_s + ADDR_W'(1'b1)) : wr_ptr_s;

    capture_addr_ctr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (wr_load_s),
        .load_val_i ({ADDR_W{1'b0}}),
        .en_i       (wren_s),
        .ptr_o      (wr_ptr_s)
    );

    capture_addr_ctr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rd_load_s),
        .load_val_i (start_addr_q),
        .en_i       (rd_en_s),
        .ptr_o      (rd_ptr_s)
    );

    // RAM address select: write pointer while capturing, read pointer while reading.
    always_comb begin
        mem_addr_o = '0;
        if (is_capture_state(state_q)) begin
            mem_addr_o = wr_ptr_s;
        end else if (is_read_state(state_q)) begin
            mem_addr_o = rd_ptr_s;
        end else begin
            mem_addr_o = '0;
        end
    end

    // Next-state, counter and pointer-control decode; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        fill_cnt_d   = fill_cnt_q;
        post_cnt_d   = post_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        out_data_d   = out_data_q;
        wr_load_s    = 1'b0;
        rd_load_s    = 1'b0;
        rd_en_s      = 1'b0;
        rst_trig_d   = 1'b0;
        done_d       = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
            if ((state_q == ST_ARMED) || (state_q == ST_POST)) begin
                rst_trig_d = 1'b1;
            end else begin
                rst_trig_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_i) begin
                        state_d    = ST_PREFILL;
                        wr_load_s  = 1'b1;
                        fill_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PREFILL: begin
                    if (wren_s) begin
                        fill_cnt_d = fill_cnt_q + ONE_C;
                        if (fill_cnt_q == PRE_LAST_C) begin
                            state_d = ST_ARMED;
                        end else begin
                            state_d = ST_PREFILL;
                        end
                    end else begin
                        state_d = ST_PREFILL;
                    end
                end
                ST_ARMED: begin
                    if (trig_i) begin
                        state_d      = ST_POST;
                        start_addr_d = wr_ptr_next_s - PRE_A;
                        post_cnt_d   = '0;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_POST: begin
                    if (wren_s) begin
                        post_cnt_d = post_cnt_q + ONE_C;
                        if (post_cnt_q == POST_LAST_C) begin
                            state_d    = ST_CLEAR;
                            rst_trig_d = 1'b1;
                        end else begin
                            state_d = ST_POST;
                        end
                    end else begin
                        state_d = ST_POST;
                    end
                end
                ST_CLEAR: begin
                    rd_load_s = 1'b1;
                    rd_cnt_d  = '0;
                    state_d   = ST_RD_ISSUE;
                end
                ST_RD_ISSUE: begin
                    state_d = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    out_data_d = mem_rdata_i;
                    state_d    = ST_RD_HOLD;
                end
                ST_RD_HOLD: begin
                    if (out_ready_i) begin
                        rd_en_s  = 1'b1;
                        rd_cnt_d = rd_cnt_q + ONE_C;
                        if (rd_cnt_q == RD_LAST_C) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RD_ISSUE;
                        end
                    end else begin
                        state_d = ST_RD_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register with Moore outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_addr_q <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            out_data_q   <= '0;
            rst_trig_q   <= 1'b0;
            done_q       <= 1'b0;
            mem_rden_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            fill_cnt_q   <= fill_cnt_d;
            post_cnt_q   <= post_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            out_data_q   <= out_data_d;
            rst_trig_q   <= rst_trig_d;
            done_q       <= done_d;
            mem_rden_q   <= (state_d == ST_RD_ISSUE);
            out_valid_q  <= (state_d == ST_RD_HOLD);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign mem_wren_o  = wren_s;
    assign mem_rden_o  = mem_rden_q;
    assign rst_trig_o  = rst_trig_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_capture_buf_sched.sv
// Scoreboard bench for capture_buf_sched (DEPTH=16, PRE_DEPTH=4) with a
// one-cycle-latency RAM model wired to the scheduler.
module tb_capture_buf_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arm = 1'b0, abort = 1'b0, sample_en = 1'b0, trig = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rst_trig, mem_wren, mem_rden, out_valid, busy, done;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata, out_data;

    logic [7:0] ram [16];

    logic [7:0] exp_q [$];
    int         n_total = 0, n_pass = 0;
    int         rt_cnt = 0, done_cnt = 0, pop_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [3:0] prev_addr = 4'h0;

    capture_buf_sched #(.ADDR_W(4), .DATA_W(8), .PRE_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .arm_i       (arm),
        .abort_i     (abort),
        .sample_en_i (sample_en),
        .trig_i      (trig),
        .rst_trig_o  (rst_trig),
        .mem_addr_o  (mem_addr),
        .mem_wren_o  (mem_wren),
        .mem_rden_o  (mem_rden),
        .mem_rdata_i (mem_rdata),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // RAM model: write-through on wren, registered read data one cycle after rden.
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= wdata;
        if (mem_rden) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: pops the scoreboard on every accepted word, checks stalls and done.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (rst_trig) rt_cnt++;
            if (done) begin
                done_cnt++;
                check("done_after_last", exp_q.size(), 0);
            end
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 1);
                check("stall_data", {24'd0, out_data}, {24'd0, prev_data});
                check("stall_addr", {28'd0, mem_addr}, {28'd0, prev_addr});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    check($sformatf("word_%0d", pop_cnt), {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                end
                pop_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = mem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sample period: strobe for one cycle, then one idle cycle.
    task automatic sample(input logic [7:0] v, input logic a);
        sample_en = 1'b1;
        wdata     = v;
        arm       = a;
        tick();
        sample_en = 1'b0;
        arm       = 1'b0;
        tick();
    endtask

    task automatic push_range(input logic [7:0] first, input int n);
        logic [7:0] v;
        v = first;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            v = v + 8'd1;
        end
    endtask

    // Full capture: arm, npre pre-trigger samples, trigger, 12 post samples.
    task automatic capture(input logic [7:0] base, input int npre, input bit trig_with_write,
                           input bit trig_early, input int arm_at);
        logic [7:0] v;
        v = base;
        if (trig_early) trig = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < npre; i++) begin
            sample(v, (i == arm_at));
            v = v + 8'd1;
        end
        trig = 1'b1;
        if (trig_with_write) begin
            sample(v, 1'b0);
            v = v + 8'd1;
        end else begin
            tick();
        end
        trig = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sample(v, 1'b0);
            v = v + 8'd1;
        end
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        n_total++;
        if (done_cnt == d0) $display("FAIL %s_done: not seen within %0d cycles", nm, budget);
        else n_pass++;
        tick();
        check({nm, "_idle"}, {27'd0, busy, mem_addr}, 0);
        check({nm, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int rt0;
        int k;
        out_ready = 1'b1;
        #12;
        check("reset_outputs", {14'd0, out_valid, busy, done, rst_trig, mem_rden, mem_wren, mem_addr, out_data}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_outputs", {14'd0, out_valid, busy, done, rst_trig, mem_rden, mem_wren, mem_addr, out_data}, 0);

        // 1: basic capture, trigger without a write in its cycle.
        rt0 = rt_cnt;
        push_range(8'd6, 16);
        capture(8'd0, 10, 1'b0, 1'b0, -1);
        check("t1_busy_during_read", {31'd0, busy}, 1);
        wait_done("t1", 200);
        check("t1_rst_trig_pulses", rt_cnt - rt0, 1);

        // 2: trigger held through prefill; readout begins at the first sample.
        push_range(8'd100, 16);
        capture(8'd100, 4, 1'b0, 1'b1, -1);
        wait_done("t2", 200);

        // 3: write in the trigger cycle is the last pre-trigger sample.
        push_range(8'h33, 16);
        capture(8'h30, 6, 1'b1, 1'b0, -1);
        wait_done("t3", 200);

        // 4: consumer stall of 5 cycles mid-readout.
        push_range(8'h50, 16);
        capture(8'h50, 4, 1'b0, 1'b0, -1);
        k = 0;
        while (pop_cnt < 53 && k < 100) begin
            tick();
            k++;
        end
        check("t4_reached_stall_point", {31'd0, (pop_cnt >= 53)}, 1);
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        wait_done("t4", 200);

        // 5: abort in POST after 3 post samples, then a clean capture.
        rt0 = rt_cnt;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 4; i++) sample(8'h70 + 8'(i), 1'b0);
        trig = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) sample(8'h74 + 8'(i), 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("t5_busy_after_abort", {31'd0, busy}, 0);
        tick();
        sample_en = 1'b1;
        wdata     = 8'h77;
        @(negedge clk);
        check("t5_no_write_after_abort", {31'd0, mem_wren}, 0);
        tick();
        sample_en = 1'b0;
        trig      = 1'b0;
        repeat (3) tick();
        check("t5_rst_trig_pulses", rt_cnt - rt0, 1);
        push_range(8'h80, 16);
        capture(8'h80, 4, 1'b0, 1'b0, -1);
        wait_done("t5", 200);

        // 6a: 30 pre-trigger samples wrap the ring; arm mid-capture ignored.
        push_range(8'hBA, 16);
        capture(8'hA0, 30, 1'b0, 1'b0, 20);
        wait_done("t6", 200);

        // 6b: asynchronous reset while holding a word.
        out_ready = 1'b0;
        capture(8'hD0, 4, 1'b0, 1'b0, -1);
        k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        check("t6_reached_hold", {31'd0, out_valid}, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_reset", {14'd0, out_valid, busy, done, rst_trig, mem_rden, mem_wren, mem_addr, out_data}, 0);
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("t6_idle_after_reset", {31'd0, busy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
